// File: rtl/wb_grf_stage.sv
// Write-back stage: decodes the retiring instruction, forms load/link/ALU write data,
// owns the 32x32 register file with write-through bypass, and counts retired instructions.
module wb_grf_stage #(
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned LINK_OFS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IR_M2W,
    input  logic [31:0] PC4_M2W,
    input  logic [31:0] ALUout_M2W,
    input  logic [31:0] DMout_M2W,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic [4:0]  WhoNew_M2W,
    output logic [31:0] WD2A3,
    output logic [31:0] RetireCnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] link_addr;
    logic [4:0]  dest;
    logic [31:0] grf [32];

    assign opcode    = IR_M2W[31:26];
    assign funct     = IR_M2W[5:0];
    assign rt        = IR_M2W[20:16];
    assign rd        = IR_M2W[15:11];
    assign off       = ALUout_M2W[1:0];
    assign link_addr = PC4_M2W + 32'(LINK_OFS);

    // Misaligned halfword/word loads simply use the aligned container.
    always_comb begin
        ld_byte = DMout_M2W[7:0];
        unique case (off)
            2'd0: ld_byte = DMout_M2W[7:0];
            2'd1: ld_byte = DMout_M2W[15:8];
            2'd2: ld_byte = DMout_M2W[23:16];
            2'd3: ld_byte = DMout_M2W[31:24];
        endcase
        ld_half = off[1] ? DMout_M2W[31:16] : DMout_M2W[15:0];
    end

    always_comb begin
        load_data = DMout_M2W;
        case (opcode)
            OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_data = {24'h0, ld_byte};
            OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_data = {16'h0, ld_half};
            default: load_data = DMout_M2W;
        endcase
    end

    always_comb begin
        dest  = 5'd0;
        WD2A3 = ALUout_M2W;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JALR) begin
                    dest  = rd;
                    WD2A3 = link_addr;
                end else if (funct != FN_JR) begin
                    dest = rd;
                end
            end
            OP_ORI, OP_LUI, OP_ADDIU, OP_SLTI: dest = rt;
            OP_JAL: begin
                dest  = 5'(LINK_REG);
                WD2A3 = link_addr;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                dest  = rt;
                WD2A3 = load_data;
            end
            default: dest = 5'd0;
        endcase
    end

    assign WhoNew_M2W = dest;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                grf[i] <= 32'h0;
            end
        end else if (WhoNew_M2W != 5'd0) begin
            grf[WhoNew_M2W] <= WD2A3;
        end
    end

    // Bypass makes a same-cycle W write visible to the D-stage read.
    always_comb begin
        if (RA1 == 5'd0)             RD1 = 32'h0;
        else if (RA1 == WhoNew_M2W)  RD1 = WD2A3;
        else                         RD1 = grf[RA1];
        if (RA2 == 5'd0)             RD2 = 32'h0;
        else if (RA2 == WhoNew_M2W)  RD2 = WD2A3;
        else                         RD2 = grf[RA2];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RetireCnt <= 32'h0;
        end else if (IR_M2W != 32'h0) begin
            RetireCnt <= RetireCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_wb_grf_stage.sv
// Bench for wb_grf_stage: directed literal checks followed by randomized traffic
// compared every cycle against an array-based architectural model.
module tb_wb_grf_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IR_M2W, PC4_M2W, ALUout_M2W, DMout_M2W;
    logic [4:0]  RA1, RA2;
    logic [31:0] RD1, RD2, WD2A3, RetireCnt;
    logic [4:0]  WhoNew_M2W;

    always #5 Clk = ~Clk;

    wb_grf_stage dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR_M2W     (IR_M2W),
        .PC4_M2W    (PC4_M2W),
        .ALUout_M2W (ALUout_M2W),
        .DMout_M2W  (DMout_M2W),
        .RA1        (RA1),
        .RA2        (RA2),
        .RD1        (RD1),
        .RD2        (RD2),
        .WhoNew_M2W (WhoNew_M2W),
        .WD2A3      (WD2A3),
        .RetireCnt  (RetireCnt)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_grf [32];
    logic [31:0] m_cnt;
    bit          m_valid = 1'b0;

    // Architectural destination of an instruction word.
    function automatic logic [4:0] m_dest(input logic [31:0] ir);
        logic [5:0] op;
        op = ir[31:26];
        if (op == 6'd0) return (ir[5:0] == 6'd8) ? 5'd0 : ir[15:11];
        if (op == 6'd3) return 5'd31;
        if (op == 6'h0d || op == 6'h0f || op == 6'h09 || op == 6'h0a) return ir[20:16];
        if (op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25)
            return ir[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] ir, input logic [31:0] pc4,
                                           input logic [31:0] alu, input logic [31:0] dm);
        int unsigned o;
        logic [31:0] b, h;
        o = alu & 32'd3;
        b = (dm >> (8 * o)) & 32'hff;
        h = (dm >> (16 * (o / 2))) & 32'hffff;
        case (ir[31:26])
            6'h00:   return (ir[5:0] == 6'd9) ? pc4 + 32'd4 : alu;
            6'h03:   return pc4 + 32'd4;
            6'h20:   return (b >= 32'h80) ? (b | 32'hffffff00) : b;
            6'h24:   return b;
            6'h21:   return (h >= 32'h8000) ? (h | 32'hffff0000) : h;
            6'h25:   return h;
            6'h23:   return dm;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra, input logic [4:0] d,
                                           input logic [31:0] w);
        if (ra == 5'd0) return 32'h0;
        if (ra == d) return w;
        return m_grf[ra];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [4:0]  d;
        logic [31:0] w;
        if (!m_valid) return;
        d = m_dest(IR_M2W);
        w = m_data(IR_M2W, PC4_M2W, ALUout_M2W, DMout_M2W);
        check("who", {27'h0, WhoNew_M2W}, {27'h0, d});
        if (d != 5'd0) check("wd", WD2A3, w);
        check("rd1", RD1, m_read(RA1, d, w));
        check("rd2", RD2, m_read(RA2, d, w));
        check("cnt", RetireCnt, m_cnt);
    endtask

    // Inputs change at the falling edge; outputs are compared 2 time units later.
    task automatic drive(input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic rst);
        IR_M2W = ir; PC4_M2W = pc4; ALUout_M2W = alu; DMout_M2W = dm;
        RA1 = ra1; RA2 = ra2; Reset = rst;
        #2;
        compare_model();
    endtask

    task automatic advance();
        logic [4:0] d;
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
            m_cnt   = 32'h0;
            m_valid = 1'b1;
        end else begin
            d = m_dest(IR_M2W);
            if (d != 5'd0) m_grf[d] = m_data(IR_M2W, PC4_M2W, ALUout_M2W, DMout_M2W);
            if (IR_M2W != 32'h0) m_cnt = m_cnt + 32'd1;
        end
        @(negedge Clk);
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        logic [5:0]  ops [16];
        ops = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h09, 6'h0a, 6'h03, 6'h23,
                6'h20, 6'h24, 6'h21, 6'h25, 6'h2b, 6'h04, 6'h02, 6'h3f};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 15)];
        if ($urandom_range(0, 1) == 1) begin
            r[20:16] = 5'($urandom_range(0, 7));
            r[15:11] = 5'($urandom_range(0, 7));
        end
        if (r[31:26] == 6'h00) begin
            case ($urandom_range(0, 3))
                0: r[5:0] = 6'd8;
                1: r[5:0] = 6'd9;
                default: r[5:0] = 6'h21;
            endcase
        end
        if ($urandom_range(0, 9) == 0) r = 32'h0;
        return r;
    endfunction

    initial begin
        m_cnt = 32'h0;
        for (int i = 0; i < 32; i++) m_grf[i] = 32'h0;
        IR_M2W = 32'h0; PC4_M2W = 32'h0; ALUout_M2W = 32'h0; DMout_M2W = 32'h0;
        RA1 = 5'd0; RA2 = 5'd0; Reset = 1'b1;
        @(negedge Clk);

        // Reset, then reads return zero.
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 1'b1);
        advance();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 1'b0);
        check("lit_reset_rd1", RD1, 32'h0);
        check("lit_reset_rd2", RD2, 32'h0);
        check("lit_reset_cnt", RetireCnt, 32'h0);
        advance();

        // ori $8 with same-cycle bypass, then GRF read.
        drive(32'h34081234, 32'h0, 32'h1234, 32'h0, 5'd8, 5'd0, 1'b0);
        check("lit_ori_who", {27'h0, WhoNew_M2W}, 32'd8);
        check("lit_ori_bypass", RD1, 32'h1234);
        advance();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd0, 1'b0);
        check("lit_ori_grf", RD1, 32'h1234);
        advance();

        // Load extraction.
        drive(32'h80090003, 32'h0, 32'h3, 32'h80FF7F01, 5'd0, 5'd0, 1'b0);
        check("lit_lb", WD2A3, 32'hFFFFFF80);
        advance();
        drive(32'h90090002, 32'h0, 32'h2, 32'h80FF7F01, 5'd0, 5'd0, 1'b0);
        check("lit_lbu", WD2A3, 32'h000000FF);
        advance();
        drive(32'h84090002, 32'h0, 32'h2, 32'h80FF7F01, 5'd0, 5'd0, 1'b0);
        check("lit_lh", WD2A3, 32'hFFFF80FF);
        advance();
        drive(32'h94090000, 32'h0, 32'h0, 32'h80FF7F01, 5'd9, 5'd0, 1'b0);
        check("lit_lhu", WD2A3, 32'h00007F01);
        check("lit_lhu_bypass", RD1, 32'h00007F01);
        advance();

        // jal links to $31.
        drive(32'h0C000C00, 32'h00003008, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
        check("lit_jal_who", {27'h0, WhoNew_M2W}, 32'd31);
        check("lit_jal_wd", WD2A3, 32'h0000300C);
        advance();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd31, 1'b0);
        check("lit_jal_rd2", RD2, 32'h0000300C);
        advance();

        // addu to $0 and sw: no write, both retire.
        drive(32'h00220021, 32'h0, 32'hDEAD, 32'h0, 5'd0, 5'd0, 1'b0);
        check("lit_r0_who", {27'h0, WhoNew_M2W}, 32'd0);
        advance();
        drive(32'hAC220004, 32'h0, 32'h4, 32'h0, 5'd0, 5'd0, 1'b0);
        check("lit_sw_who", {27'h0, WhoNew_M2W}, 32'd0);
        advance();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd8, 1'b0);
        check("lit_cnt8", RetireCnt, 32'd8);
        check("lit_lhu_grf", RD1, 32'h00007F01);
        advance();

        // Reset suppresses a pending write.
        drive(32'h34040055, 32'h0, 32'h55, 32'h0, 5'd4, 5'd0, 1'b1);
        advance();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd4, 5'd8, 1'b0);
        check("lit_rst_rd1", RD1, 32'h0);
        check("lit_rst_rd2", RD2, 32'h0);
        check("lit_rst_cnt", RetireCnt, 32'h0);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(rand_ir(), {$urandom_range(0, 32'h3fff_ffff), 2'b00}, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 49) == 0));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_grf_stage.md
Name: wb_grf_stage

Overview:
- Write-back (W) stage of the 5-stage MIPS pipeline; consumes the M→W pipeline registers (IR_M2W, PC4_M2W, ALUout_M2W, DMout_M2W).
- Decodes the retiring instruction, extracts and extends load data, and selects the write-back value and destination register.
- Owns the 32x32 general register file, with two read ports for the D stage and internal write-through bypass.
- Drives WhoNew_M2W / WD2A3 back to the M and E stages for forwarding, and keeps a retired-instruction counter.

Parameters:
- LINK_REG, 31, destination register for jal.
- LINK_OFS, 4, offset added to PC4_M2W to form the link address (delay slot, so link = PC+8).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- IR_M2W  input  32  retiring instruction.
- PC4_M2W  input  32  PC+4 of the retiring instruction.
- ALUout_M2W  input  32  ALU result; bits [1:0] are the load byte offset.
- DMout_M2W  input  32  raw aligned data-memory word.
- RA1  input  5  D-stage read address 1 (rs).
- RA2  input  5  D-stage read address 2 (rt).
- RD1  output  32  read data 1.
- RD2  output  32  read data 2.
- WhoNew_M2W  output  5  destination register of the retiring instruction; 0 means no write.
- WD2A3  output  32  write-back data.
- RetireCnt  output  32  count of retired non-nop instructions.

Behaviour:
- Decode uses opcode IR[31:26] and funct IR[5:0]. Destination and data per instruction class:
  - R-type (op 0, funct not jr 001000 and not jalr 001001): dest = rd, data = ALUout.
  - jalr: dest = rd, data = PC4_M2W + LINK_OFS.
  - jr: no write.
  - ori 001101, lui 001111, addiu 001001, slti 001010: dest = rt, data = ALUout.
  - jal 000011: dest = LINK_REG, data = PC4 + LINK_OFS.
  - Loads: dest = rt, data = extended load value.
  - All others (sw/sh/sb, beq, bne, j, unknown opcodes, IR = 0): WhoNew_M2W = 0, no write.
- Load extraction uses off = ALUout_M2W[1:0]; little-endian, byte k = DMout[8k+7:8k].
  - lw 100011: whole word.
  - lb 100000: byte[off], sign-extended. lbu 100100: byte[off], zero-extended.
  - lh 100001: halfword at off[1] (off[1]=0 gives [15:0], 1 gives [31:16]), sign-extended. lhu 100101: same halfword, zero-extended.
  - Misaligned lh/lhu (off[0]=1) or lw (off≠0) uses the aligned word/halfword (ignores the low bits); no trap.
- WhoNew_M2W and WD2A3 are purely combinational from the M2W inputs, so they are valid in the same cycle. If the destination is register 0, WhoNew_M2W = 0.
- Register file:
  - Write on rising Clk when Reset=0 and WhoNew_M2W≠0: GRF[WhoNew_M2W] ← WD2A3.
  - Register 0 always reads 0.
- Reads are combinational with write-through bypass: RDn = 0 if RAn=0; else WD2A3 if RAn = WhoNew_M2W; else GRF[RAn]. A D-stage read in the same cycle as a W write therefore sees the new value (half-cycle-equivalent behaviour).
- Reset (synchronous, rising Clk with Reset=1):
  - All GRF entries and RetireCnt are cleared to 0; any write presented in that cycle is suppressed.
  - After reset every RDn reads 0 until written.
  - Reset mid-stream discards the retiring write.
- RetireCnt increments by 1 on each rising Clk with Reset=0 and IR_M2W≠0, including stores and branches. It wraps from FFFFFFFF to 0.
- Latency: write data becomes architecturally visible in GRF from the next cycle; it is visible through the bypass in the same cycle.

Test Plan:
- Reset, then RA1=5, RA2=0 → RD1=0, RD2=0, RetireCnt=0.
- IR=ori $8,$0,0x1234 (0x34081234), ALUout=0x1234; same cycle RA1=8 → WhoNew_M2W=8, RD1=0x00001234 via bypass. Next cycle, with IR=0 → RD1=0x1234 from GRF.
- DMout=0x80FF7F01, IR=lb $9 with ALUout low bits 3 → WD2A3=0xFFFFFF80. lbu off 2 → 0x000000FF. lh off 2 → 0xFFFF80FF. lhu off 0 → 0x00007F01.
- IR=jal (0x0C000C00), PC4=0x00003008 → WhoNew_M2W=31, WD2A3=0x0000300C. Next cycle, RA2=31 → RD2=0x300C.
- IR=addu $0,$1,$2, ALUout=0xDEAD → WhoNew_M2W=0, GRF[0] stays 0. A sw instruction → no write, but RetireCnt increments.
- Write $4=0x55 pending with Reset=1 in the same cycle → after the edge RD1(RA1=4)=0 and RetireCnt=0.
